// File: rtl/ac_upsp_pkg.sv
// Shared types and register bit positions for the up-sampler access controller.
package ac_upsp_pkg;

   localparam int unsigned PIXEL_WIDTH     = 24;
   localparam int unsigned UPSTR_START_BIT = 0;
   localparam int unsigned UPENDR_DONE_BIT = 0;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ac_state_e;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/ac_upsp_access_if.sv
// Host control, source stream, up-sampler read/write channels and output stream.
// slave = access controller view, master = surrounding system view.
interface ac_upsp_access_if #(
   parameter int unsigned UPSP_DATA_WIDTH = 24,
   parameter int unsigned CRF_DATA_WIDTH  = 32
);

   logic                       host_start;
   logic                       host_busy;
   logic                       host_done;

   logic                       s_axis_tvalid;
   logic                       s_axis_tready;
   logic [UPSP_DATA_WIDTH-1:0] s_axis_tdata;

   logic [CRF_DATA_WIDTH-1:0]  UPSTR;
   logic [CRF_DATA_WIDTH-1:0]  UPENDR;

   logic                       upsp_ac_rready;
   logic                       ac_upsp_rvalid;
   logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata;

   logic                       ac_upsp_wready;
   logic                       upsp_ac_wvalid;
   logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata;

   logic                       m_axis_tvalid;
   logic                       m_axis_tready;
   logic [UPSP_DATA_WIDTH-1:0] m_axis_tdata;
   logic                       m_axis_tlast;

   modport slave (
      input  host_start, s_axis_tvalid, s_axis_tdata, UPENDR, upsp_ac_rready,
             upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
      output host_busy, host_done, s_axis_tready, UPSTR, ac_upsp_rvalid, ac_upsp_rdata,
             ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );

   modport master (
      output host_start, s_axis_tvalid, s_axis_tdata, UPENDR, upsp_ac_rready,
             upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
      input  host_busy, host_done, s_axis_tready, UPSTR, ac_upsp_rvalid, ac_upsp_rdata,
             ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );

endinterface

// File: rtl/ac_sync_fifo.sv
// Synchronous first-word fall-through FIFO; DEPTH must be a power of two.
module ac_sync_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB tells full from empty when the indices match.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign rdata   = mem[rptr[AW-1:0]];

   // Pointer update; indices wrap modulo DEPTH through natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage write, no reset needed on the data array.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ac_upsp_access.sv
// Access controller: buffers source pixels for the up-sampler, forwards its results
// downstream and sequences one frame per host start via UPSTR/UPENDR.
module ac_upsp_access
   import ac_upsp_pkg::*;
#(
   parameter int unsigned CRF_DATA_WIDTH  = 32,
   parameter int unsigned UPSP_DATA_WIDTH = PIXEL_WIDTH,
   parameter int unsigned SRC_PIXELS      = 518400,
   parameter int unsigned DST_PIXELS      = 8294400,
   parameter int unsigned FIFO_DEPTH      = 16
) (
   input logic          clk,
   input logic          rst,
   ac_upsp_access_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DST_PIXELS + 1);
   localparam logic [CNT_W-1:0] SRC_MAX  = CNT_W'(SRC_PIXELS);
   localparam logic [CNT_W-1:0] DST_MAX  = CNT_W'(DST_PIXELS);
   localparam logic [CNT_W-1:0] DST_LAST = CNT_W'(DST_PIXELS - 1);

   ac_state_e state, state_nxt;

   logic [CNT_W-1:0] in_cnt, out_cnt, tx_cnt;

   logic [UPSP_DATA_WIDTH-1:0] in_head, out_head;
   logic in_full, in_empty, out_full, out_empty;
   logic run;
   logic s_fire, r_fire, w_fire, m_fire;
   logic unused_upendr_bits;

   assign unused_upendr_bits = ^bus.UPENDR;

   assign run    = (state == RUN);
   assign s_fire = bus.s_axis_tvalid && bus.s_axis_tready;
   assign r_fire = bus.ac_upsp_rvalid && bus.upsp_ac_rready;
   assign w_fire = bus.upsp_ac_wvalid && bus.ac_upsp_wready;
   assign m_fire = bus.m_axis_tvalid && bus.m_axis_tready;

   // Ready/valid gating; data outputs are masked while empty so idle outputs read 0.
   assign bus.s_axis_tready  = run && !in_full && (in_cnt < SRC_MAX);
   assign bus.ac_upsp_rvalid = !in_empty;
   assign bus.ac_upsp_rdata  = in_empty ? '0 : in_head;
   assign bus.ac_upsp_wready = run && !out_full && (out_cnt < DST_MAX);
   assign bus.m_axis_tvalid  = !out_empty;
   assign bus.m_axis_tdata   = out_empty ? '0 : out_head;
   assign bus.m_axis_tlast   = !out_empty && (tx_cnt == DST_LAST);

   ac_sync_fifo #(.WIDTH(UPSP_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) in_fifo (
      .clk(clk), .rst(rst),
      .push(s_fire), .wdata(bus.s_axis_tdata),
      .pop(r_fire), .rdata(in_head),
      .full(in_full), .empty(in_empty)
   );

   ac_sync_fifo #(.WIDTH(UPSP_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) out_fifo (
      .clk(clk), .rst(rst),
      .push(w_fire), .wdata(bus.upsp_ac_wdata),
      .pop(m_fire), .rdata(out_head),
      .full(out_full), .empty(out_empty)
   );

   // Frame state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and host/register outputs.
   always_comb begin
      state_nxt     = state;
      bus.host_busy = 1'b0;
      bus.host_done = 1'b0;
      bus.UPSTR     = '0;
      case (state)
         IDLE: begin
            if (bus.host_start) state_nxt = RUN;
         end
         RUN: begin
            bus.host_busy              = 1'b1;
            bus.UPSTR[UPSTR_START_BIT] = 1'b1;
            if (in_cnt == SRC_MAX && out_cnt == DST_MAX) state_nxt = FLUSH;
         end
         FLUSH: begin
            bus.host_busy              = 1'b1;
            bus.UPSTR[UPSTR_START_BIT] = 1'b1;
            if (tx_cnt == DST_MAX && bus.UPENDR[UPENDR_DONE_BIT]) state_nxt = DONE;
         end
         DONE: begin
            bus.host_done = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer counters: cleared on frame start, saturating at their limits.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && bus.host_start)) begin
         in_cnt  <= '0;
         out_cnt <= '0;
         tx_cnt  <= '0;
      end else begin
         if (s_fire && in_cnt < SRC_MAX)  in_cnt  <= in_cnt + CNT_W'(1);
         if (w_fire && out_cnt < DST_MAX) out_cnt <= out_cnt + CNT_W'(1);
         if (m_fire && tx_cnt < DST_MAX)  tx_cnt  <= tx_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ac_upsp_access.sv
// Directed bench for ac_upsp_access with a small frame (4 source / 64 output pixels).
module tb_ac_upsp_access;
   import ac_upsp_pkg::*;

   localparam int SRC    = 4;
   localparam int DST    = 64;
   localparam int DEPTH  = 4;
   localparam int BUDGET = 400;
   localparam int NFRM   = 7;

   typedef struct {
      int n_offer;
      int bp;
      int early_end;
      int rst_at;
      int start_mid;
      int rd_hold;
      int exp_src;
      int exp_done;
   } frame_cfg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ac_upsp_access_if #(.UPSP_DATA_WIDTH(24), .CRF_DATA_WIDTH(32)) bus ();

   ac_upsp_access #(
      .CRF_DATA_WIDTH(32), .UPSP_DATA_WIDTH(24), .SRC_PIXELS(SRC),
      .DST_PIXELS(DST), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cur   = -1;
   frame_cfg_t cfgs [NFRM];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL frame%0d %s: got 0x%0h, expected 0x%0h", cur, nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.host_start     = 1'b0;
      bus.s_axis_tvalid  = 1'b0;
      bus.s_axis_tdata   = '0;
      bus.UPENDR         = '0;
      bus.upsp_ac_rready = 1'b0;
      bus.upsp_ac_wvalid = 1'b0;
      bus.upsp_ac_wdata  = '0;
      bus.m_axis_tready  = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},   32'(bus.host_busy),      0);
      chk({tag, "_done"},   32'(bus.host_done),      0);
      chk({tag, "_stready"},32'(bus.s_axis_tready),  0);
      chk({tag, "_upstr"},  bus.UPSTR,               0);
      chk({tag, "_rvalid"}, 32'(bus.ac_upsp_rvalid), 0);
      chk({tag, "_rdata"},  32'(bus.ac_upsp_rdata),  0);
      chk({tag, "_wready"}, 32'(bus.ac_upsp_wready), 0);
      chk({tag, "_tvalid"}, 32'(bus.m_axis_tvalid),  0);
      chk({tag, "_tdata"},  32'(bus.m_axis_tdata),   0);
      chk({tag, "_tlast"},  32'(bus.m_axis_tlast),   0);
   endtask

   task automatic run_frame(input int k);
      frame_cfg_t c;
      int src_acc, rd_n, wr_n, rx_n, done_n, stall, cyc;
      bit fin, did_rst, s_f, r_f, w_f, m_f;
      pixel_t exp_px;
      c = cfgs[k];
      cur = k;
      src_acc = 0; rd_n = 0; wr_n = 0; rx_n = 0; done_n = 0; stall = 0; cyc = 0;
      fin = 0; did_rst = 0;

      drive_idle();
      chk("pre_busy", 32'(bus.host_busy), 0);
      bus.host_start = 1'b1;
      @(negedge clk);
      bus.host_start = 1'b0;

      while (!fin && cyc < BUDGET) begin
         bus.s_axis_tvalid  = (src_acc < c.n_offer);
         bus.s_axis_tdata   = 24'(src_acc + 1);
         bus.upsp_ac_rready = !(c.rd_hold != 0 && cyc < 15);
         bus.upsp_ac_wvalid = (wr_n < DST);
         bus.upsp_ac_wdata  = 24'(24'h100000 + wr_n);
         bus.m_axis_tready  = !(c.bp != 0 && rx_n >= 20 && stall < 20);
         // upper UPENDR bits are kept set to show they are ignored
         bus.UPENDR         = 32'hFFFF_FFFE |
                              32'((c.early_end != 0) ? (wr_n >= 10) : (rx_n >= DST));
         bus.host_start     = (c.start_mid != 0 && cyc == 40);

         if (c.rst_at > 0 && wr_n == c.rst_at && !did_rst) begin
            did_rst = 1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_zero("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            drive_idle();
            break;
         end

         #1;
         s_f = bus.s_axis_tvalid && bus.s_axis_tready;
         r_f = bus.ac_upsp_rvalid && bus.upsp_ac_rready;
         w_f = bus.upsp_ac_wvalid && bus.ac_upsp_wready;
         m_f = bus.m_axis_tvalid && bus.m_axis_tready;

         if (r_f) chk("rdata", 32'(bus.ac_upsp_rdata), 32'(rd_n + 1));
         if (m_f) begin
            exp_px = pixel_t'(24'h100000 + rx_n);
            chk("tdata", 32'(bus.m_axis_tdata), 32'(exp_px));
            chk("tlast", 32'(bus.m_axis_tlast), 32'(rx_n == DST - 1));
         end
         if (src_acc >= SRC) chk("stready_sat", 32'(bus.s_axis_tready), 0);
         if (wr_n >= DST)    chk("wready_sat",  32'(bus.ac_upsp_wready), 0);
         if (c.rd_hold != 0 && cyc == 14) chk("rvalid_held", 32'(bus.ac_upsp_rvalid), 1);
         if (c.bp != 0 && stall == 19) begin
            chk("bp_wready", 32'(bus.ac_upsp_wready), 0);
            chk("bp_tvalid", 32'(bus.m_axis_tvalid),  1);
            chk("bp_buffered", 32'(wr_n - rx_n), 32'(DEPTH));
         end

         if (bus.host_done) begin
            done_n++;
            fin = 1;
            chk("done_beats", 32'(rx_n), 32'(DST));
            chk("done_upstr", bus.UPSTR, 0);
            chk("done_busy",  32'(bus.host_busy), 0);
         end else begin
            chk("busy", 32'(bus.host_busy), 1);
            chk("upstr", bus.UPSTR, 1);
         end

         @(posedge clk);
         if (s_f) src_acc++;
         if (r_f) rd_n++;
         if (w_f) wr_n++;
         if (m_f) rx_n++;
         if (c.bp != 0 && rx_n >= 20 && stall < 20 && !m_f) stall++;
         cyc++;
         @(negedge clk);
      end

      drive_idle();
      if (!did_rst) begin
         if (!fin) chk("timeout", 0, 1);
         chk("after_done", 32'(bus.host_done), 0);
         chk("after_busy", 32'(bus.host_busy), 0);
         chk("after_upstr", bus.UPSTR, 0);
         chk("beats", 32'(rx_n), 32'(DST));
         chk("src_read", 32'(rd_n), 32'(c.exp_src));
      end
      chk("src_accepted", 32'(src_acc), 32'(c.exp_src));
      chk("done_count", 32'(done_n), 32'(c.exp_done));
      @(negedge clk);
      chk("idle_busy", 32'(bus.host_busy), 0);
   endtask

   initial begin
      // n_offer, bp, early_end, rst_at, start_mid, rd_hold, exp_src, exp_done
      cfgs[0] = '{4, 0, 0, 0,  0, 0, 4, 1};   // nominal
      cfgs[1] = '{6, 0, 0, 0,  0, 0, 4, 1};   // source overrun
      cfgs[2] = '{4, 1, 0, 0,  0, 0, 4, 1};   // downstream back-pressure
      cfgs[3] = '{4, 0, 1, 0,  0, 0, 4, 1};   // early UPENDR
      cfgs[4] = '{4, 0, 0, 30, 0, 0, 4, 0};   // reset mid-frame
      cfgs[5] = '{4, 0, 0, 0,  0, 0, 4, 1};   // clean frame after reset
      cfgs[6] = '{4, 0, 0, 0,  1, 1, 4, 1};   // start while busy, source FIFO full

      drive_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("idle");

      for (int k = 0; k < NFRM; k++) run_frame(k);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
